// File: rtl/turf_bus_pkg.sv
// Shared types and constants for the TURF register bus responder.
// State encoding, bus geometry and the bank field position.
package turf_bus_pkg;

  localparam int TURF_ADDR_W = 8;
  localparam int TURF_BYTES  = 4;
  localparam int BANK_MSB    = 7;
  localparam int BANK_LSB    = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_RWAIT,
    ST_RDATA,
    ST_DONE
  } turf_state_e;

endpackage

// File: rtl/turf_bus_shreg.sv
// 32-bit byte shift register shared by the read and write paths.
// Ports: i_load/i_load_dat parallel load, i_shift/i_sin LSB-first shift, o_q contents.
module turf_bus_shreg (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [31:0] i_load_dat,
  input  logic        i_shift,
  input  logic [7:0]  i_sin,
  output logic [31:0] o_q
);

  logic [31:0] r_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_dat;
    end else if (i_shift) begin
      r_q <= {i_sin, r_q[31:8]};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/turf_bus_responder.sv
// TURF-end responder: byte-wide TURF bus to 32-bit register strobes.
// Ports: ncs/wnr/dio bus side, reg_* register side, busy_o, abort_cnt_o.
module turf_bus_responder
  import turf_bus_pkg::*;
#(
  parameter int RD_LATENCY     = 1,
  parameter int ABORT_CNT_BITS = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      ncs_i,
  input  logic                      wnr_i,
  input  logic [7:0]                dio_i,
  output logic [7:0]                dio_o,
  output logic                      dio_oe_o,
  output logic [TURF_ADDR_W-1:0]    reg_addr_o,
  output logic                      reg_wr_o,
  output logic [31:0]               reg_dat_o,
  output logic                      reg_rd_o,
  input  logic [31:0]               reg_dat_i,
  output logic                      busy_o,
  output logic [ABORT_CNT_BITS-1:0] abort_cnt_o
);

  localparam logic [1:0] LAST_BYTE = 2'(TURF_BYTES - 1);
  localparam logic [1:0] LAT_LAST  = 2'(RD_LATENCY);

  turf_state_e               r_state;
  logic [1:0]                r_byte_cnt;
  logic [1:0]                r_lat_cnt;
  logic                      r_oe;
  logic                      r_wr;
  logic                      r_rd;
  logic [TURF_ADDR_W-1:0]    r_addr;
  logic [31:0]               r_dat;
  logic [ABORT_CNT_BITS-1:0] r_abort_cnt;

  logic                      w_abort;
  logic                      w_sr_load;
  logic                      w_sr_shift;
  logic [31:0]               w_sr_q;
  logic [TURF_ADDR_W-1:0]    w_cap_addr;

  assign w_cap_addr = {dio_i[BANK_MSB:BANK_LSB], dio_i[BANK_LSB-1:0]};

  // ncs high in any mid-transaction state ends it early
  assign w_abort = ncs_i && (r_state == ST_WDATA ||
                             r_state == ST_RWAIT ||
                             r_state == ST_RDATA);

  assign w_sr_load  = !ncs_i && r_state == ST_RWAIT &&
                      r_lat_cnt == LAT_LAST;
  assign w_sr_shift = !ncs_i &&
                      (r_state == ST_WDATA ||
                       (r_state == ST_RDATA && r_byte_cnt != LAST_BYTE));

  turf_bus_shreg u_shreg (
    .i_clk      (clk_i),
    .i_rst_n    (rst_n_i),
    .i_load     (w_sr_load),
    .i_load_dat (reg_dat_i),
    .i_shift    (w_sr_shift),
    .i_sin      (dio_i),
    .o_q        (w_sr_q)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_byte_cnt  <= '0;
      r_lat_cnt   <= '0;
      r_oe        <= 1'b0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_addr      <= '0;
      r_dat       <= '0;
      r_abort_cnt <= '0;
    end else begin
      r_wr <= 1'b0;
      r_rd <= 1'b0;
      if (w_abort && r_abort_cnt != '1) begin
        r_abort_cnt <= r_abort_cnt + 1'b1;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (!ncs_i) begin
            r_addr     <= w_cap_addr;
            r_byte_cnt <= '0;
            r_lat_cnt  <= '0;
            if (wnr_i) begin
              r_state <= ST_WDATA;
            end else begin
              r_rd    <= 1'b1;
              r_state <= ST_RWAIT;
            end
          end
        end
        ST_WDATA: begin
          if (ncs_i) begin
            r_state <= ST_IDLE;
          end else begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == LAST_BYTE) begin
              // last byte goes straight from the bus into the held copy
              r_dat   <= {dio_i, w_sr_q[31:8]};
              r_wr    <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_RWAIT: begin
          if (ncs_i) begin
            r_state <= ST_IDLE;
          end else if (r_lat_cnt == LAT_LAST) begin
            r_oe       <= 1'b1;
            r_byte_cnt <= '0;
            r_state    <= ST_RDATA;
          end else begin
            r_lat_cnt <= r_lat_cnt + 2'd1;
          end
        end
        ST_RDATA: begin
          if (ncs_i) begin
            r_oe    <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_byte_cnt == LAST_BYTE) begin
            r_oe    <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        ST_DONE: begin
          if (ncs_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_oe    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dio_o       = w_sr_q[7:0];
  assign dio_oe_o    = r_oe;
  assign reg_addr_o  = r_addr;
  assign reg_wr_o    = r_wr;
  assign reg_dat_o   = r_dat;
  assign reg_rd_o    = r_rd;
  assign busy_o      = (r_state != ST_IDLE);
  assign abort_cnt_o = r_abort_cnt;

endmodule
